uart_tx_monitor: RTL and testbench
==================================

# uart_tx_monitor

Synthesizable UART receiver that sits directly downstream of the SoC's `serial_tx` pin in the tinyfpga simulation targets. It decodes 8N1 frames from the CPU's UART and buffers the bytes in a small FIFO. A valid/ready interface lets bench logic, or a later on-board loopback checker, consume console output without parsing the VCD. It also flags framing errors and FIFO overflow.

## Interface
Parameters:
- `CLK_DIV`, default 278: sys_clk cycles per bit (32 MHz / 115200 baud); legal range ≥ 8.
- `FIFO_DEPTH`, default 4: bytes buffered; power of two, ≥ 2.

Ports:
- `sys_clk`  in  1  system clock, 32 MHz. Single clock domain.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `serial_rx`  in  1  asynchronous line input; idles high; connected to the SoC `serial_tx`.
- `m_data`  out  8  head-of-FIFO byte.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid && m_ready`.
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse; held 0 unless `UART_MON_PARITY_EN` is defined.
- `overflow`  out  1  sticky; set when a good byte arrives with the FIFO full and no pop in that cycle.

## Operation
- `serial_rx` passes through a 2-flop synchronizer; the FSM sees only the synchronized signal `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP, BREAK.
- IDLE: a falling edge on `rx_s` loads the bit counter with CLK_DIV/2 − 1 and moves to START.
- START: at counter zero, sample `rx_s`. If low, enter DATA and reload CLK_DIV−1. If high, treat as a glitch and return to IDLE.
- DATA: sample once every CLK_DIV cycles, LSB first, into a shift register. After the 8th bit, go to PARITY or STOP.
- STOP: sample `rx_s`.
  - High: push the byte and return to IDLE.
  - Low: pulse `frame_err`, discard the byte, and enter BREAK.
- BREAK: wait for `rx_s` high, then go to IDLE.
- FIFO push and pop behaviour:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; this is not an overflow.
  - A push with the FIFO full and no pop drops the byte and sets `overflow`.
  - No fall-through: a byte pushed into an empty FIFO appears on `m_data` the next cycle.
- Pointers wrap modulo FIFO_DEPTH. `level` counts 0..FIFO_DEPTH.
- Reset values: `m_data`=0x00, `m_valid`=0, `level`=0, `frame_err`=0, `parity_err`=0, `overflow`=0, FSM in IDLE, synchronizer flops preset to 1.
- Reset asserted mid-frame abandons the frame. After release, the next falling edge starts a new frame.

## Timing
- Take t0 as the sys_clk edge at which `serial_rx` is first seen low.
  - Start-bit sample: t0+2+CLK_DIV/2.
  - Data bit k (k = 0..7) sample: start sample + (k+1)·CLK_DIV.
  - Stop-bit sample: start sample + 9·CLK_DIV, or + 10·CLK_DIV with parity enabled.
- `m_valid` rises 1 cycle after the stop sample.
- With CLK_DIV=278 and no parity, `m_valid` rises at t0+2644.
- `frame_err` and `parity_err` pulse in the cycle after the stop sample.
- Pop latency: after an accepted pop, the next entry appears on `m_data` the following cycle.

## Configuration
- `UART_MON_PARITY_EN`, defined:
  - Adds the PARITY state; one even-parity bit is expected after D7.
  - On mismatch, `parity_err` pulses and the byte is discarded. The stop bit is still checked.
- `UART_MON_PARITY_EN`, undefined:
  - 8N1 only; `parity_err` is tied to 0 and no parity logic is synthesized.

## Structure
- Shared package `uart_mon_pkg`:
  - FSM state enum `uart_mon_state_t`.
  - `UART_DATA_BITS`=8.
  - Function `uart_half_div(div)`.
- Sub-module `uart_mon_fifo`: synchronous FIFO with registered output, parameterized width and depth, exposing full, empty and level. The top level holds the synchronizer, bit timer and FSM.

## Test plan
- Send 0x55 at 115200 baud with `m_ready`=1 → `m_valid` for exactly 1 cycle at t0+2644 with `m_data`=0x55, no error pulses.
- Send 0xA5 with the stop bit driven low, then hold the line low for 2 bit times → one `frame_err` pulse, `m_valid` stays 0, and the next frame 0x3C is received correctly.
- Drive a 50-cycle low glitch on an idle line → no byte, no error, FSM back in IDLE by cycle 143.
- Hold `m_ready`=0 and send 0x01..0x05 → `level`=4, `overflow`=1 after the 5th byte. Then raise `m_ready` → bytes pop out as 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
- Assert `sys_rst_n`=0 for 3 cycles during data bit 3 of 0xFF → all outputs reset. Then send 0x81 → 0x81 received with no error.
- With `UART_MON_PARITY_EN` defined, send 0x07 with parity bit 0 (wrong) → `parity_err` pulse, no byte. Then send 0x07 with parity bit 1 → 0x07 delivered.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types, constants and helpers for the UART console monitor.
// The PARITY state is only reachable when UART_MON_PARITY_EN is defined.
package uart_mon_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5
    } uart_mon_state_t;

    // Cycles from the detected falling edge to the middle of the start bit.
    function automatic int unsigned uart_half_div(input int unsigned div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_mon_if.sv
// Byte stream carrying decoded console output from the monitor to its consumer.
interface uart_mon_if;
    import uart_mon_pkg::*;

    logic [UART_DATA_BITS-1:0] m_data;
    logic                      m_valid;
    logic                      m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/uart_mon_fifo.sv
// Synchronous FIFO with registered storage and no fall-through; a simultaneous
// push and pop on a full FIFO is honoured.
module uart_mon_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign head  = mem_q[rptr_q];

    // When full, a pop frees the slot the write pointer is aimed at.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_data;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_monitor.sv
// 8N1 UART receiver buffering console bytes in a FIFO with valid/ready output.
// Define UART_MON_PARITY_EN to expect one even-parity bit after D7.
module uart_tx_monitor
    import uart_mon_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 278,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         serial_rx,
    uart_mon_if.master                   mon,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overflow
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(uart_half_div(CLK_DIV) - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = StIdle;
    localparam logic [2:0] S_START  = StStart;
    localparam logic [2:0] S_DATA   = StData;
    localparam logic [2:0] S_STOP   = StStop;
    localparam logic [2:0] S_BREAK  = StBreak;
`ifdef UART_MON_PARITY_EN
    localparam logic [2:0] S_PARITY = StParity;
`endif

    logic                      sync1_q, rx_s, rx_prev_q;
    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      push_q, push_d;
    logic [UART_DATA_BITS-1:0] push_data_q;
    logic                      ferr_q, ferr_d;
    logic                      ovf_q;
    logic                      tick;
    logic                      fifo_full, fifo_empty, fifo_pop;
`ifdef UART_MON_PARITY_EN
    logic                      par_bad_q, par_bad_d;
    logic                      perr_q, perr_d;
`endif

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_MON_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    // A start bit that is high again mid-bit was only a glitch.
                    if (!rx_s) begin
                        state_d = S_DATA;
                        cnt_d   = FULL_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    cnt_d   = FULL_LOAD;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_MON_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_MON_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_bad_d = ^{shift_q, rx_s};
                    state_d   = S_STOP;
                    cnt_d     = FULL_LOAD;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
`ifdef UART_MON_PARITY_EN
                    if (par_bad_q) begin
                        push_d = 1'b0;
                        perr_d = 1'b1;
                    end
`endif
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_q     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q   <= serial_rx;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
            if (push_d) begin
                push_data_q <= shift_q;
            end
            if (push_q && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef UART_MON_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign fifo_pop  = !fifo_empty && mon.m_ready;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;
    assign mon.m_valid = !fifo_empty;

    uart_mon_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (fifo_pop),
        .head      (mon.m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Directed bench for uart_tx_monitor at the default 115200-baud divider.
// Also builds with UART_MON_PARITY_EN defined to exercise the parity path.
module tb_uart_tx_monitor;

    localparam int unsigned CLK_DIV    = 278;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_MON_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Drive-to-m_valid latency: first edge seeing low (+1), then 2644 (+1 bit with parity).
    localparam int EXP_LAT = 2645 + PAR_BITS * int'(CLK_DIV);

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       serial_rx = 1'b1;
    logic [2:0] level;
    logic       frame_err, parity_err, overflow;

    uart_mon_if mon_if ();

    uart_tx_monitor #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .serial_rx  (serial_rx),
        .mon        (mon_if.master),
        .level      (level),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Observation counters, written only here.
    int         rise_cyc = -1;
    int         n_vhi = 0, n_ferr = 0, n_perr = 0;
    logic [7:0] rx_q[$];
    int         pop_cyc[$];

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (mon_if.m_valid) begin
                if (n_vhi == 0 || rise_cyc != cyc - 1) rise_cyc = cyc;
                n_vhi++;
            end
            if (mon_if.m_valid && mon_if.m_ready) begin
                rx_q.push_back(mon_if.m_data);
                pop_cyc.push_back(cyc);
            end
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame, each bit held CLK_DIV cycles; the line keeps the stop level for tail_low more.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                              input int tail_low, output int t);
        @(posedge sys_clk); #1;
        serial_rx = 1'b0;
        t = cyc;
        repeat (CLK_DIV) @(posedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            #1 serial_rx = data[i];
            repeat (CLK_DIV) @(posedge sys_clk);
        end
        if (PAR_BITS != 0) begin
            #1 serial_rx = par_bit;
            repeat (CLK_DIV) @(posedge sys_clk);
        end
        #1 serial_rx = stop_bit;
        repeat (CLK_DIV) @(posedge sys_clk);
        repeat (tail_low) @(posedge sys_clk);
        #1 serial_rx = 1'b1;
    endtask

    int t, b_q, b_vhi, b_ferr, b_perr;

    task automatic snap();
        b_q    = rx_q.size();
        b_vhi  = n_vhi;
        b_ferr = n_ferr;
        b_perr = n_perr;
    endtask

    initial begin
        mon_if.m_ready = 1'b1;

        // Reset state
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("rst_m_valid", 32'(mon_if.m_valid), 0);
        check_eq("rst_m_data", 32'(mon_if.m_data), 0);
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_frame_err", 32'(frame_err), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        @(posedge sys_clk); #1 sys_rst_n = 1'b1;
        repeat (20) @(posedge sys_clk);

        // 0x55: m_valid for exactly one cycle at the fixed latency
        snap();
        send_frame(8'h55, 1'b1, 1'b0, 0, t);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("55_latency", 32'(rise_cyc - t), 32'(EXP_LAT));
        check_eq("55_valid_cycles", 32'(n_vhi - b_vhi), 1);
        check_eq("55_count", 32'(rx_q.size() - b_q), 1);
        check_eq("55_data", 32'(rx_q[rx_q.size()-1]), 32'h55);
        check_eq("55_ferr", 32'(n_ferr - b_ferr), 0);
        check_eq("55_perr", 32'(n_perr - b_perr), 0);

        // 0xA5 with low stop bit and a two-bit break, then a good 0x3C
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 2 * CLK_DIV, t);
        repeat (20) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("a5_ferr", 32'(n_ferr - b_ferr), 1);
        check_eq("a5_no_byte", 32'(rx_q.size() - b_q), 0);
        check_eq("a5_no_valid", 32'(n_vhi - b_vhi), 0);
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 0, t);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("3c_count", 32'(rx_q.size() - b_q), 1);
        check_eq("3c_data", 32'(rx_q[rx_q.size()-1]), 32'h3C);
        check_eq("3c_ferr", 32'(n_ferr - b_ferr), 0);

        // 50-cycle glitch: rejected at the start-bit sample
        snap();
        @(posedge sys_clk); #1 serial_rx = 1'b0;
        t = cyc;
        repeat (50) @(posedge sys_clk);
        #1 serial_rx = 1'b1;
        @(negedge sys_clk);
        check_eq("glitch_in_start", 32'(dut.state_q), 1);
        repeat (94) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("glitch_idle_143", 32'(dut.state_q), 0);
        check_eq("glitch_no_byte", 32'(rx_q.size() - b_q), 0);
        check_eq("glitch_ferr", 32'(n_ferr - b_ferr), 0);

        // Backpressure: five bytes into a four-deep FIFO
        mon_if.m_ready = 1'b0;
        snap();
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, ^8'(i), 0, t);
        end
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("bp_level4", 32'(level), 4);
        check_eq("bp_no_ovf_yet", 32'(overflow), 0);
        send_frame(8'h05, 1'b1, 1'b0, 0, t);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("bp_level_full", 32'(level), 4);
        check_eq("bp_overflow", 32'(overflow), 1);
        @(posedge sys_clk); #1 mon_if.m_ready = 1'b1;
        repeat (8) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("bp_pop_count", 32'(rx_q.size() - b_q), 4);
        if (rx_q.size() - b_q == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("bp_pop%0d_data", i), 32'(rx_q[b_q+i]), 32'(i + 1));
                check_eq($sformatf("bp_pop%0d_cyc", i), 32'(pop_cyc[b_q+i] - pop_cyc[b_q]),
                         32'(i));
            end
        end
        check_eq("bp_level_drained", 32'(level), 0);
        check_eq("bp_ovf_sticky", 32'(overflow), 1);

        // Reset during data bit 3 of 0xFF, then a clean 0x81
        snap();
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 0, t);
            begin
                repeat (1200) @(posedge sys_clk);
                #1 sys_rst_n = 1'b0;
                repeat (3) @(posedge sys_clk);
                @(negedge sys_clk);
                check_eq("mid_rst_m_valid", 32'(mon_if.m_valid), 0);
                check_eq("mid_rst_m_data", 32'(mon_if.m_data), 0);
                check_eq("mid_rst_level", 32'(level), 0);
                check_eq("mid_rst_overflow", 32'(overflow), 0);
                check_eq("mid_rst_state", 32'(dut.state_q), 0);
                @(posedge sys_clk); #1 sys_rst_n = 1'b1;
            end
        join
        repeat (20) @(posedge sys_clk);
        send_frame(8'h81, 1'b1, 1'b0, 0, t);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("81_count", 32'(rx_q.size() - b_q), 1);
        check_eq("81_data", 32'(rx_q[rx_q.size()-1]), 32'h81);
        check_eq("81_ferr", 32'(n_ferr - b_ferr), 0);

`ifdef UART_MON_PARITY_EN
        // 0x07 has three ones, so even parity needs a 1
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 0, t);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("par_bad_perr", 32'(n_perr - b_perr), 1);
        check_eq("par_bad_no_byte", 32'(rx_q.size() - b_q), 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 0, t);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("par_ok_perr", 32'(n_perr - b_perr), 0);
        check_eq("par_ok_count", 32'(rx_q.size() - b_q), 1);
        check_eq("par_ok_data", 32'(rx_q[rx_q.size()-1]), 32'h07);
`else
        check_eq("no_parity_pulses", 32'(n_perr), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
